ps2_key_tracker: RTL and testbench

- Sits between the PS/2 serial byte receiver and the position-control FSM.
- Turns the raw scan-code byte stream into a level "key held" signal plus the held make code. The FSM consumes these as received_data_en / received_data: it leaves IDLE on en rising and leaves LOAD_DIRECTION on en falling.
- Handles 0xF0 break and 0xE0 extended prefixes, typematic repeats, and controller status bytes.
- A stuck-key timeout guarantees the FSM is never left in LOAD_DIRECTION forever.

---
 rtl/ps2_key_tracker_pkg.sv | 48 ++++
 rtl/ps2_key_tracker_if.sv | 29 ++
 rtl/ps2_hold_timer.sv | 44 ++++
 rtl/ps2_key_tracker.sv | 134 +++++++++++++
 tb/tb_ps2_key_tracker.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/ps2_key_tracker_pkg.sv
// ---------------------------------------------------------------------------
// ps2_codes_pkg
// Shared PS/2 scan-code constants, the prefix-state encoding and the decoded
// key-action record used by ps2_key_tracker. The movement codes are the ones
// the position-control FSM compares received_data against.
// ---------------------------------------------------------------------------
package ps2_codes_pkg;

  // Prefix bytes
  localparam logic [7:0] PS2_EXT        = 8'hE0;
  localparam logic [7:0] PS2_BRK        = 8'hF0;
  localparam logic [7:0] PS2_FAKE_SHIFT = 8'h12;

  // Controller status / protocol bytes (never scan codes)
  localparam logic [7:0] PS2_STAT_ZERO   = 8'h00;
  localparam logic [7:0] PS2_STAT_BAT_OK = 8'hAA;
  localparam logic [7:0] PS2_STAT_ACK    = 8'hFA;
  localparam logic [7:0] PS2_STAT_RESEND = 8'hFE;
  localparam logic [7:0] PS2_STAT_ERROR  = 8'hFF;

  // Movement make codes shared with the position FSM
  localparam logic [7:0] KEY_W = 8'h1D;
  localparam logic [7:0] KEY_A = 8'h1C;
  localparam logic [7:0] KEY_S = 8'h1B;
  localparam logic [7:0] KEY_D = 8'h23;

  // Which prefix bytes have been seen since the last complete code
  typedef enum logic [1:0] {
    S_BASE = 2'd0,
    S_E0   = 2'd1,
    S_F0   = 2'd2,
    S_E0F0 = 2'd3
  } prefixState_t;

  // Result of decoding one byte in the current prefix state
  typedef struct packed {
    logic make;  // byte completes a make code
    logic brk;   // byte completes a break code
    logic ext;   // the completed code was E0-prefixed
  } keyAction_t;

  function automatic logic isStatusByte(input logic [7:0] b);
    return (b == PS2_STAT_ZERO)   || (b == PS2_STAT_BAT_OK) ||
           (b == PS2_STAT_ACK)    || (b == PS2_STAT_RESEND) ||
           (b == PS2_STAT_ERROR);
  endfunction

endpackage

// File: rtl/ps2_key_tracker_if.sv
// ---------------------------------------------------------------------------
// ps2_key_tracker_if
// Byte stream in from the PS/2 receiver, held-key state out to the FSM.
//   ps2_byte / ps2_byte_valid   : byte and its one-cycle strobe
//   received_data               : held make code, 0x00 when nothing held
//   received_data_en            : high while a key is held
//   extended                    : held key was E0-prefixed
//   key_event                   : one-cycle pulse on every new press
// modport slave  : the tracker
// modport master : the environment (receiver side + FSM side)
// ---------------------------------------------------------------------------
interface ps2_key_tracker_if;
  logic [7:0] ps2_byte;
  logic       ps2_byte_valid;
  logic [7:0] received_data;
  logic       received_data_en;
  logic       extended;
  logic       key_event;

  modport slave (
    input  ps2_byte, ps2_byte_valid,
    output received_data, received_data_en, extended, key_event
  );

  modport master (
    output ps2_byte, ps2_byte_valid,
    input  received_data, received_data_en, extended, key_event
  );
endinterface

// File: rtl/ps2_hold_timer.sv
// ---------------------------------------------------------------------------
// ps2_hold_timer
// Counts idle cycles while a key is held; expire fires for one cycle when the
// count reaches TIMEOUT_CYCLES-1, which the tracker turns into a release.
//   clock, resetn : clock, synchronous active-low reset
//   clear         : synchronous flush, counter to 0
//   run           : a key is held (count only while high)
//   kick          : a byte was strobed this cycle (reload to 0)
//   expire        : combinational, one cycle, counter returns to 0 after it
// TIMEOUT_CYCLES = 0 disables the timer (counter held at 0, expire never).
// ---------------------------------------------------------------------------
module ps2_hold_timer #(
  parameter int TIMEOUT_CYCLES = 25_000_000,
  parameter int TIMEOUT_W      = 25
) (
  input  logic clock,
  input  logic resetn,
  input  logic clear,
  input  logic run,
  input  logic kick,
  output logic expire
);

  localparam bit ENABLED = (TIMEOUT_CYCLES != 0);
  localparam logic [TIMEOUT_W-1:0] LAST_COUNT =
    ENABLED ? TIMEOUT_W'(TIMEOUT_CYCLES - 1) : '0;

  logic [TIMEOUT_W-1:0] count;

  // A strobe in the same cycle always wins over expiry: the byte is live
  // traffic, so the key cannot be considered stuck.
  assign expire = ENABLED && run && !kick && (count == LAST_COUNT);

  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge values; blocking = here would create order-dependent races.
  always_ff @(posedge clock) begin
    if (!resetn || clear || !ENABLED || !run || kick || expire) begin
      count <= '0;
    end else begin
      count <= count + TIMEOUT_W'(1);
    end
  end

endmodule

// File: rtl/ps2_key_tracker.sv
// ---------------------------------------------------------------------------
// ps2_key_tracker
// Turns the raw PS/2 scan-code byte stream into a level "key held" signal
// plus the held make code, for the position-control FSM.
//   clock   : system clock
//   resetn  : synchronous active-low reset
//   clear   : synchronous flush (game reset), same effect as reset
//   bus     : ps2_key_tracker_if.slave (byte stream in, held key out)
// Handles E0/F0 prefixes, typematic repeats, status bytes and a stuck-key
// timeout. All outputs are registered; a byte strobed at cycle n is visible
// at cycle n+1.
// ---------------------------------------------------------------------------
module ps2_key_tracker
  import ps2_codes_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 25_000_000,
  parameter int TIMEOUT_W      = 25
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               clear,
  ps2_key_tracker_if.slave   bus
);

  prefixState_t state;
  prefixState_t stateNext;
  keyAction_t   action;

  logic       heldMatch;
  logic       expire;
  logic [7:0] dataNext;
  logic       enNext;
  logic       extNext;
  logic       eventNext;

  ps2_hold_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TIMEOUT_W      (TIMEOUT_W)
  ) u_hold_timer (
    .clock  (clock),
    .resetn (resetn),
    .clear  (clear),
    .run    (bus.received_data_en),
    .kick   (bus.ps2_byte_valid),
    .expire (expire)
  );

  // State register and registered outputs. Reset and clear override a
  // same-cycle strobe, so that byte is simply dropped.
  always_ff @(posedge clock) begin
    if (!resetn || clear) begin
      state                <= S_BASE;
      bus.received_data    <= '0;
      bus.received_data_en <= 1'b0;
      bus.extended         <= 1'b0;
      bus.key_event        <= 1'b0;
    end else begin
      state                <= stateNext;
      bus.received_data    <= dataNext;
      bus.received_data_en <= enNext;
      bus.extended         <= extNext;
      bus.key_event        <= eventNext;
    end
  end

  // Next prefix state and the action the current byte completes.
  // NOTE: every variable written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    stateNext = state;
    action    = '0;
    if (bus.ps2_byte_valid) begin
      case (state)
        S_BASE: begin
          if (bus.ps2_byte == PS2_EXT) begin
            stateNext = S_E0;
          end else if (bus.ps2_byte == PS2_BRK) begin
            stateNext = S_F0;
          end else if (!isStatusByte(bus.ps2_byte)) begin
            action.make = 1'b1;
          end
        end
        S_E0: begin
          stateNext = S_BASE;
          if (isStatusByte(bus.ps2_byte)) begin
            stateNext = S_BASE;
          end else if (bus.ps2_byte == PS2_BRK) begin
            stateNext = S_E0F0;
          end else if (bus.ps2_byte == PS2_EXT) begin
            stateNext = S_E0;
          end else if (bus.ps2_byte != PS2_FAKE_SHIFT) begin
            action.make = 1'b1;
            action.ext  = 1'b1;
          end
        end
        S_F0: begin
          stateNext  = S_BASE;
          action.brk = !isStatusByte(bus.ps2_byte);
        end
        S_E0F0: begin
          stateNext  = S_BASE;
          action.brk = !isStatusByte(bus.ps2_byte);
          action.ext = 1'b1;
        end
        default: stateNext = S_BASE;
      endcase
    end
  end

  // Byte names exactly the key currently held (code and ext bit both).
  assign heldMatch = bus.received_data_en &&
                     (bus.received_data == bus.ps2_byte) &&
                     (bus.extended == action.ext);

  // Next output values. A make of the held key is a typematic repeat and
  // changes nothing; a break of anything but the held key is stale.
  always_comb begin
    dataNext  = bus.received_data;
    enNext    = bus.received_data_en;
    extNext   = bus.extended;
    eventNext = 1'b0;
    if (action.make && !heldMatch) begin
      dataNext  = bus.ps2_byte;
      extNext   = action.ext;
      enNext    = 1'b1;
      eventNext = 1'b1;
    end else if ((action.brk && heldMatch) || expire) begin
      dataNext = '0;
      extNext  = 1'b0;
      enNext   = 1'b0;
    end
  end

endmodule

// File: tb/tb_ps2_key_tracker.sv
// ---------------------------------------------------------------------------
// tb_ps2_key_tracker
// Directed scenarios followed by randomized byte traffic, every cycle checked
// against a reference model of held-key behaviour kept in this bench.
// ---------------------------------------------------------------------------
module tb_ps2_key_tracker;
  import ps2_codes_pkg::*;

  localparam int TMO = 16;

  logic clock = 1'b0;
  logic resetn;
  logic clear;

  ps2_key_tracker_if bus ();

  ps2_key_tracker #(
    .TIMEOUT_CYCLES (TMO),
    .TIMEOUT_W      (5)
  ) dut (
    .clock  (clock),
    .resetn (resetn),
    .clear  (clear),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  int errorCount = 0;
  int checkCount = 0;

  // Reference model: what key the user is holding, plus the pending prefixes
  logic       mHeld;
  logic [7:0] mCode;
  logic       mExt;
  logic       mEvent;
  logic       sawE0;
  logic       sawF0;
  int         quiet;

  logic [7:0] statusCodes [5] = '{8'h00, 8'hAA, 8'hFA, 8'hFE, 8'hFF};
  logic [7:0] pool [12] = '{8'h1D, 8'h1C, 8'h1B, 8'h23, 8'hE0, 8'hF0,
                            8'hF0, 8'h12, 8'h75, 8'hAA, 8'hFE, 8'h6B};

  task automatic check(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("FAIL %s @%0t: got %02h expected %02h", tag, $time, got, exp);
    end
  endtask

  function automatic bit isStatus(input logic [7:0] b);
    foreach (statusCodes[i]) if (statusCodes[i] == b) return 1'b1;
    return 1'b0;
  endfunction

  task automatic releaseKey();
    mHeld = 1'b0;
    mCode = 8'h00;
    mExt  = 1'b0;
  endtask

  task automatic modelPress(input logic [7:0] c, input logic e);
    if (!(mHeld && mCode == c && mExt == e)) begin
      mHeld  = 1'b1;
      mCode  = c;
      mExt   = e;
      mEvent = 1'b1;
    end
  endtask

  task automatic modelStep(input logic v, input logic [7:0] b,
                           input logic clr, input logic rn);
    mEvent = 1'b0;
    if (!rn || clr) begin
      releaseKey();
      sawE0 = 1'b0;
      sawF0 = 1'b0;
      quiet = 0;
    end else if (v) begin
      quiet = 0;
      if (isStatus(b)) begin
        sawE0 = 1'b0;
        sawF0 = 1'b0;
      end else if (sawF0) begin
        if (mHeld && mCode == b && mExt == sawE0) releaseKey();
        sawE0 = 1'b0;
        sawF0 = 1'b0;
      end else if (b == 8'hF0) begin
        sawF0 = 1'b1;
      end else if (b == 8'hE0) begin
        sawE0 = 1'b1;
      end else if (sawE0 && b == 8'h12) begin
        sawE0 = 1'b0;
      end else begin
        modelPress(b, sawE0);
        sawE0 = 1'b0;
      end
    end else begin
      quiet++;
      if (mHeld && quiet >= TMO) releaseKey();
    end
  endtask

  // One clock: apply inputs, advance model at the edge, compare after it.
  task automatic step(input logic v, input logic [7:0] b,
                      input logic clr, input logic rn);
    bus.ps2_byte       = b;
    bus.ps2_byte_valid = v;
    clear              = clr;
    resetn             = rn;
    @(posedge clock);
    modelStep(v, b, clr, rn);
    #1;
    check("received_data", bus.received_data, mCode);
    check("received_data_en", {7'd0, bus.received_data_en}, {7'd0, mHeld});
    check("extended", {7'd0, bus.extended}, {7'd0, mExt});
    check("key_event", {7'd0, bus.key_event}, {7'd0, mEvent});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic sendByte(input logic [7:0] b);
    step(1'b1, b, 1'b0, 1'b1);
    idle(1);
  endtask

  initial begin
    bus.ps2_byte       = 8'h00;
    bus.ps2_byte_valid = 1'b0;
    clear              = 1'b0;
    resetn             = 1'b0;
    mHeld = 1'b0; mCode = 8'h00; mExt = 1'b0; mEvent = 1'b0;
    sawE0 = 1'b0; sawF0 = 1'b0; quiet = 0;

    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    idle(2);

    // Press, typematic repeats, release
    sendByte(KEY_W);
    repeat (3) sendByte(KEY_W);
    sendByte(8'hF0); sendByte(KEY_W);

    // Replace, stale release, real release
    sendByte(KEY_W); sendByte(KEY_A);
    sendByte(8'hF0); sendByte(KEY_W);
    sendByte(8'hF0); sendByte(KEY_A);

    // Extended keys and fake shift
    sendByte(8'hE0); sendByte(8'h75);
    sendByte(8'hF0); sendByte(8'h75);
    sendByte(8'hE0); sendByte(8'hF0); sendByte(8'h75);
    sendByte(8'hE0); sendByte(8'h12); sendByte(KEY_W);
    sendByte(8'hF0); sendByte(KEY_W);

    // Status bytes, and a status byte aborting a break
    sendByte(8'hAA); sendByte(8'hFA);
    sendByte(8'hF0); sendByte(8'hFE); sendByte(KEY_W);

    // Back-to-back strobes
    step(1'b1, 8'hF0, 1'b0, 1'b1);
    step(1'b1, KEY_W, 1'b0, 1'b1);
    step(1'b1, KEY_D, 1'b0, 1'b1);
    idle(1);

    // Timeout: exact expiry, then a restart by a repeat at cycle 10
    sendByte(KEY_S);
    idle(TMO + 2);
    step(1'b1, KEY_S, 1'b0, 1'b1);
    idle(9);
    step(1'b1, KEY_S, 1'b0, 1'b1);
    idle(TMO + 2);

    // Prefix survives a timeout
    sendByte(KEY_D);
    step(1'b1, 8'hE0, 1'b0, 1'b1);
    idle(TMO + 2);
    sendByte(8'h75);

    // Reset drops a pending F0; clear wins over a same-cycle strobe
    sendByte(8'hF0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    sendByte(KEY_W);
    step(1'b1, KEY_D, 1'b1, 1'b1);
    idle(1);
    step(1'b1, KEY_D, 1'b0, 1'b0);
    idle(1);

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      int r;
      logic [7:0] b;
      r = int'($urandom_range(0, 99));
      if (r < 75) b = pool[$urandom_range(0, 11)];
      else b = 8'($urandom_range(0, 255));
      r = int'($urandom_range(0, 99));
      if (r < 2)      step(1'b1, b, 1'b1, 1'b1);
      else if (r < 3) step(1'b1, b, 1'b0, 1'b0);
      else            step(1'b1, b, 1'b0, 1'b1);
      r = int'($urandom_range(0, 9));
      if (r < 2)      idle(0);
      else if (r < 8) idle(int'($urandom_range(1, 3)));
      else            idle(int'($urandom_range(TMO - 3, TMO + 2)));
    end

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
